// File: rtl/perf_cnt_sampler_pkg.sv
// Shared types and constants for the performance counter sweep sampler.
// Sample bundle, FSM states and counter word address helper.
package perf_cnt_sampler_pkg;

  localparam int PERF_NCOUNTERS   = 5;
  localparam int PERF_NTHREADS    = 4;
  localparam int PERF_TID_W       = 2;
  localparam int PERF_AWIDTH      = 8;
  localparam int PERF_RETRY_LIMIT = 64;

  typedef enum logic [1:0] {
    IDLE,
    REQ_HI,
    REQ_LO,
    EMIT
  } perf_sampler_state_e;

  typedef struct packed {
    logic [PERF_TID_W-1:0] tid;
    logic [2:0]            cnt;
    logic [63:0]           value;
    logic [15:0]           seq;
    logic                  err;
  } perf_sample_t;

  // Counter c occupies word 2c (high half) and 2c+1 (low half).
  function automatic logic [PERF_AWIDTH-1:0] perf_word_addr(
    input logic [2:0] cnt,
    input logic       half
  );
    logic [PERF_AWIDTH-1:0] w;
    w = {{(PERF_AWIDTH-4){1'b0}}, cnt, half};
    return w << 2;
  endfunction

endpackage

// File: rtl/perf_cnt_sampler_timer.sv
// Sweep period timer: down-counter with reload on change or expiry.
// Emits a one-cycle trigger each time the count reaches zero.
module perf_cnt_sampler_timer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic [31:0] period_i,
  output logic        trig_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] period_q;

  // Next count: a new period restarts the countdown from scratch.
  always_comb begin
    count_d = count_q;
    trig_o  = 1'b0;
    if (period_i != period_q) begin
      count_d = period_i - 32'd1;
    end else if (enable_i && (period_i != 32'd0)) begin
      if (count_q == 32'd0) begin
        trig_o  = 1'b1;
        count_d = period_i - 32'd1;
      end else begin
        count_d = count_q - 32'd1;
      end
    end
  end

  // Count and last-seen period registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q  <= period_i - 32'd1;
      period_q <= period_i;
    end else begin
      count_q  <= count_d;
      period_q <= period_i;
    end
  end

endmodule

// File: rtl/perf_cnt_sampler.sv
// Sweeps every thread/counter through the counter io-bus read port
// and streams assembled 64-bit samples out on a valid/ready link.
module perf_cnt_sampler
  import perf_cnt_sampler_pkg::*;
#(
  parameter int RETRY_LIMIT = PERF_RETRY_LIMIT
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic [31:0]            period_i,
  input  logic                   start_now_i,
  output logic                   pc_en_o,
  output logic [PERF_AWIDTH-1:0] pc_addr_o,
  output logic [PERF_TID_W-1:0]  pc_tid_o,
  input  logic [31:0]            pc_rdata_i,
  input  logic                   pc_retry_i,
  output logic                   smp_valid_o,
  input  logic                   smp_ready_i,
  output logic [PERF_TID_W-1:0]  smp_tid_o,
  output logic [2:0]             smp_cnt_o,
  output logic [63:0]            smp_value_o,
  output logic [15:0]            smp_seq_o,
  output logic                   smp_err_o,
  output logic                   busy_o,
  output logic                   overrun_o,
  input  logic                   clear_overrun_i
);

  localparam int RW = $clog2(RETRY_LIMIT + 1);
  localparam logic [RW-1:0] RLAST = RW'(RETRY_LIMIT - 1);
  localparam logic [2:0] CLAST = 3'(PERF_NCOUNTERS - 1);
  localparam logic [PERF_TID_W-1:0] TLAST =
    PERF_TID_W'(PERF_NTHREADS - 1);

  perf_sampler_state_e state_q, state_d;
  perf_sample_t        smp_q, smp_d;
  logic [RW-1:0]       retry_q, retry_d;
  logic                gap_q, gap_d;
  logic                ovr_q, ovr_d;
  logic                tmr_trig;
  logic                trig;
  logic                accept;
  logic                abandon;
  logic                pc_en;

  perf_cnt_sampler_timer u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .enable_i (enable_i),
    .period_i (period_i),
    .trig_o   (tmr_trig)
  );

  assign trig    = tmr_trig | start_now_i;
  assign accept  = pc_en & ~pc_retry_i;
  assign abandon = pc_en & pc_retry_i & (retry_q == RLAST);

  // Sweep FSM: word requests, retry timeout, sample hand-off, cursors.
  always_comb begin
    state_d = state_q;
    smp_d   = smp_q;
    retry_d = retry_q;
    gap_d   = gap_q;
    ovr_d   = ovr_q;
    pc_en   = 1'b0;

    if (trig && (state_q != IDLE)) begin
      ovr_d = 1'b1;
    end else if (clear_overrun_i) begin
      ovr_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (trig) begin
          state_d   = REQ_HI;
          gap_d     = 1'b0;
          retry_d   = '0;
          smp_d.err = 1'b0;
        end
      end
      REQ_HI, REQ_LO: begin
        pc_en = ~gap_q;
        if (gap_q) begin
          gap_d = 1'b0;
        end else if (accept || abandon) begin
          retry_d   = '0;
          smp_d.err = smp_q.err | abandon;
          if (state_q == REQ_HI) begin
            smp_d.value[63:32] = accept ? pc_rdata_i : 32'd0;
            state_d = REQ_LO;
            gap_d   = 1'b1;
          end else begin
            smp_d.value[31:0] = accept ? pc_rdata_i : 32'd0;
            state_d = EMIT;
          end
        end else if (pc_retry_i) begin
          retry_d = retry_q + RW'(1);
        end
      end
      EMIT: begin
        if (smp_ready_i) begin
          smp_d.err = 1'b0;
          state_d   = REQ_HI;
          if (smp_q.cnt == CLAST) begin
            smp_d.cnt = 3'd0;
            if (smp_q.tid == TLAST) begin
              smp_d.tid = '0;
              smp_d.seq = smp_q.seq + 16'd1;
              state_d   = IDLE;
            end else begin
              smp_d.tid = smp_q.tid + PERF_TID_W'(1);
            end
          end else begin
            smp_d.cnt = smp_q.cnt + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, sample buffer and sticky overrun registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      smp_q   <= '0;
      retry_q <= '0;
      gap_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      smp_q   <= smp_d;
      retry_q <= retry_d;
      gap_q   <= gap_d;
      ovr_q   <= ovr_d;
    end
  end

  assign pc_en_o     = pc_en;
  assign pc_addr_o   = perf_word_addr(smp_q.cnt, state_q == REQ_LO);
  assign pc_tid_o    = smp_q.tid;
  assign smp_valid_o = (state_q == EMIT);
  assign smp_tid_o   = smp_q.tid;
  assign smp_cnt_o   = smp_q.cnt;
  assign smp_value_o = smp_q.value;
  assign smp_seq_o   = smp_q.seq;
  assign smp_err_o   = smp_q.err;
  assign busy_o      = (state_q != IDLE);
  assign overrun_o   = ovr_q;

endmodule

// File: doc/perf_cnt_sampler.md
Name: perf_cnt_sampler

Overview:
Autonomous sweep controller for the per-thread performance counter block. It periodically, or on a one-shot trigger, walks every thread and every counter and reads each 64-bit count as two 32-bit words through the counter block's io-bus read port, honouring its retry handshake. It delivers each assembled sample on a valid/ready stream toward the host trace/DMA path. It is the sole requester on that read port when instantiated.

Parameters:
NCOUNTERS, 5, counters per thread (ldst, cti, flop, intop, rw_state), counter index c maps to word addresses 2c/2c+1
RETRY_LIMIT, 64, max consecutive retry cycles per word before the word is abandoned
NTHREADS, NTHREAD (libconf), threads swept; tid width NTHREADIDMSB+1

Ports:
gclk  in  iu_clk_type  clock bundle; only posedge gclk.clk is used
rst  in  1  synchronous, active-high reset
enable  in  1  periodic sweeping allowed
period  in  32  cycles between sweep starts; 0 = periodic off
start_now  in  1  one-cycle pulse: start a sweep
pc_en  out  1  read request to counter block
pc_addr  out  IO_AWIDTH  byte address = word index << 2; word 2c = bits[63:32], 2c+1 = bits[31:0]
pc_tid  out  NTHREADIDMSB+1  thread whose counter is read
pc_rdata  in  32  read data, valid when pc_en & ~pc_retry
pc_retry  in  1  counter block not ready; hold request
smp_valid  out  1  sample available
smp_ready  in  1  consumer accepts sample
smp_tid  out  NTHREADIDMSB+1  sample thread
smp_cnt  out  3  sample counter index
smp_value  out  64  {hi, lo}
smp_seq  out  16  sweep number, wraps at 2^16
smp_err  out  1  a word timed out; its half reads 0
busy  out  1  sweep in progress
overrun  out  1  sticky: a trigger arrived while busy
clear_overrun  in  1  clears overrun

Behaviour:
- Reset: all outputs 0; state IDLE; period timer loaded with period-1; seq 0; tid/cnt cursors 0.
- Period timer: decrements each cycle while enable & period != 0; reload to period-1 on reaching 0 or whenever period changes. At 0, issues a trigger.
- Trigger = timer trigger | start_now. In IDLE: next cycle state REQ_HI, busy=1. If busy: trigger dropped, overrun set. When set and clear_overrun coincide, set wins.
- REQ_HI / REQ_LO: pc_en=1, pc_tid=tid cursor, pc_addr=(2*cnt + (state==REQ_LO))<<2. Address and tid stay stable while pc_retry=1.
- Word accepted in a cycle with pc_en & ~pc_retry: capture pc_rdata into the hi or lo register. REQ_HI goes to REQ_LO; REQ_LO goes to EMIT.
- pc_en drops for at least 1 cycle between words, because the counter block's retry is registered. Minimum 2 cycles per word.
- Retry counter resets per word. After RETRY_LIMIT consecutive retry cycles: word = 0, err flag set for the sample, advance as if accepted.
- EMIT: smp_valid=1 with registered fields. Fields stay stable until smp_valid & smp_ready. On handshake: cnt+1. At cnt==NCOUNTERS-1, wrap cnt to 0 and tid+1. At the last tid and last cnt: seq+1, go to IDLE (busy=0). Otherwise go to REQ_HI. No new request is issued while a sample is pending (single buffer).
- Hi is read before lo, so the 64-bit value is not atomic. Consumers tolerate low-word carry tearing.
- Sample order: tid 0..NTHREADS-1 outer, cnt 0..NCOUNTERS-1 inner.
- enable deasserted mid-sweep: the sweep completes and only the timer stops. rst mid-sweep: everything to reset values immediately, pc_en=0 in the following cycle.
- period < sweep length: every timer trigger during a sweep sets overrun.

Decomposition:
- libperfcnt: PERF_NCOUNTERS constant; perf_sample_type struct {tid, cnt, value, seq, err}; perf_sampler_state_type enum {IDLE, REQ_HI, REQ_LO, EMIT}; function perf_word_addr(cnt, half).
- Sub-module perf_sample_timer: period down-counter, reload-on-change, trigger pulse.

Test Plan:
- NTHREADS=4, period=0, start_now pulse, counter model always ready with value tid*16+c -> 20 samples in order, values exact, smp_seq=0, then busy=0 with smp_seq=1 afterwards.
- Model retries 3 cycles per word -> pc_addr/pc_tid stable during retry, values correct, smp_err=0.
- Model retries forever on tid 2 cnt 1 lo -> abandoned after 64 cycles, that sample has lo=0 and smp_err=1, sweep continues.
- smp_ready low for 10 cycles at sample 5 -> fields held, no pc_en during the stall, no sample lost or duplicated.
- period=50 with a sweep longer than 50 cycles -> overrun=1. clear_overrun in the same cycle as a new drop keeps it 1; clear alone clears it.
- rst asserted mid-REQ_LO -> next cycle pc_en=0, smp_valid=0, busy=0; after release, start_now sweep begins at tid 0 cnt 0.
